// File: rtl/orgasmall_pkg.sv
// Shared types and helpers for the program loader.
// Optional build macro LOADER_CHECKSUM_EN enables the trailing XOR checksum byte.
package orgasmall_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ADDR   = 3'd1,
      LEN    = 3'd2,
      DATA   = 3'd3,
      WRITE  = 3'd4,
      CHECK  = 3'd5,
      FINISH = 3'd6
   } loader_state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   localparam int WORD_SIZE_DEFAULT = 32'sd8;

   localparam int ADDR_SIZE_DEFAULT = 32'sd8;

   // Number of whole bytes needed to carry a field of the given bit width.
   function automatic int bytes_for(input int bits);
      return (bits + 32'sd7) / 32'sd8;
   endfunction

   // Running XOR checksum update for one accepted byte.
   function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/program_loader_byte_shifter.sv
// byte_shifter: MSB-first byte accumulator shared by every multi-byte field.
// A load shifts one byte in; 'full' flags the load that completes a field of
// 'target' bytes. Clear wins over load so a field can be closed and the
// accumulator emptied in the same cycle.
module byte_shifter #(
   parameter int NBYTES = 1,
   parameter int CW     = $clog2(NBYTES + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  load,
   input  logic [7:0]            byte_in,
   input  logic [CW-1:0]         target,
   output logic [NBYTES*8-1:0]   value_next,
   output logic                  full
);

   localparam int SW = NBYTES * 8;

   logic [SW-1:0]   shreg_r;
   logic [CW-1:0]   count_r;
   logic [SW+7:0]   cat_s;

   // Value the register would hold after shifting in byte_in; older high bytes fall off.
   always_comb begin
      cat_s      = {shreg_r, byte_in};
      value_next = cat_s[SW-1:0];
      if (load && ((count_r + CW'(1)) == target)) begin
         full = 1'b1;
      end else begin
         full = 1'b0;
      end
   end

   // Shift register and byte counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg_r <= {SW{1'b0}};
         count_r <= {CW{1'b0}};
      end else if (clear) begin
         shreg_r <= {SW{1'b0}};
         count_r <= {CW{1'b0}};
      end else if (load) begin
         shreg_r <= value_next;
         count_r <= count_r + CW'(1);
      end else begin
         shreg_r <= shreg_r;
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/program_loader.sv
// program_loader: framed byte-stream boot loader driving the main memory write port.
// Frame: SYNC, ADDR, LEN (word count), LEN words, optional CHK.
// Build macro LOADER_CHECKSUM_EN adds the CHK byte and the CHECK state; without it
// error is permanently 0.
module program_loader
   import orgasmall_pkg::*;
#(
   parameter int         WORD_SIZE = WORD_SIZE_DEFAULT,
   parameter int         ADDR_SIZE = ADDR_SIZE_DEFAULT,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [WORD_SIZE-1:0]  mem_data,
   output logic [ADDR_SIZE-1:0]  mem_addr,
   output logic                  mem_en_write,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error
);

   localparam int BPW = bytes_for(WORD_SIZE);
   localparam int ABW = bytes_for(ADDR_SIZE);
   localparam int NB  = (ABW > BPW) ? ABW : BPW;
   localparam int CW  = $clog2(NB + 1);
   localparam int SW  = NB * 8;

   localparam logic [CW-1:0] ABW_C = CW'(ABW);
   localparam logic [CW-1:0] BPW_C = CW'(BPW);

`ifdef LOADER_CHECKSUM_EN
   localparam loader_state_t END_STATE = CHECK;
`else
   localparam loader_state_t END_STATE = FINISH;
`endif

   loader_state_t           state_r;
   loader_state_t           state_s;

   logic                    accept_s;
   logic                    sh_load_s;
   logic                    sh_clear_s;
   logic [CW-1:0]           sh_target_s;
   logic [SW-1:0]           sh_value_s;
   logic                    sh_full_s;
   logic                    fin_ok_s;
   logic [ADDR_SIZE-1:0]    field_s;
   logic [ADDR_SIZE-1:0]    idx_inc_s;

   logic [ADDR_SIZE-1:0]    base_r;
   logic [ADDR_SIZE-1:0]    len_r;
   logic [ADDR_SIZE-1:0]    idx_r;
   logic [WORD_SIZE-1:0]    mem_data_r;
   logic [ADDR_SIZE-1:0]    mem_addr_r;
   logic                    mem_en_write_r;
   logic                    in_ready_r;
   logic                    cpu_hold_r;
   logic                    done_r;
   logic                    error_r;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]              chk_r;
`endif

   assign accept_s  = in_valid && in_ready_r;
   assign field_s   = sh_value_s[ADDR_SIZE-1:0];
   assign idx_inc_s = idx_r + ADDR_SIZE'(1);

   byte_shifter #(
      .NBYTES (NB),
      .CW     (CW)
   ) u_shifter (
      .clk        (clk),
      .rst        (rst),
      .clear      (sh_clear_s),
      .load       (sh_load_s),
      .byte_in    (in_data),
      .target     (sh_target_s),
      .value_next (sh_value_s),
      .full       (sh_full_s)
   );

   // Next-state logic and shifter control for the frame parser.
   always_comb begin
      state_s     = state_r;
      sh_load_s   = 1'b0;
      sh_clear_s  = 1'b0;
      sh_target_s = ABW_C;
      fin_ok_s    = 1'b1;
      case (state_r)
         IDLE: begin
            if (accept_s && (in_data == SYNC_BYTE)) begin
               sh_clear_s = 1'b1;
               state_s    = ADDR;
            end else begin
               state_s    = IDLE;
            end
         end
         ADDR: begin
            sh_load_s = accept_s;
            if (sh_full_s) begin
               sh_clear_s = 1'b1;
               state_s    = LEN;
            end else begin
               state_s    = ADDR;
            end
         end
         LEN: begin
            sh_load_s = accept_s;
            if (sh_full_s) begin
               sh_clear_s = 1'b1;
               if (field_s == {ADDR_SIZE{1'b0}}) begin
                  state_s = END_STATE;
               end else begin
                  state_s = DATA;
               end
            end else begin
               state_s = LEN;
            end
         end
         DATA: begin
            sh_target_s = BPW_C;
            sh_load_s   = accept_s;
            if (sh_full_s) begin
               sh_clear_s = 1'b1;
               state_s    = WRITE;
            end else begin
               state_s    = DATA;
            end
         end
         WRITE: begin
            if (idx_inc_s == len_r) begin
               state_s = END_STATE;
            end else begin
               state_s = DATA;
            end
         end
         CHECK: begin
`ifdef LOADER_CHECKSUM_EN
            if (accept_s) begin
               fin_ok_s = (in_data == chk_r);
               state_s  = FINISH;
            end else begin
               state_s  = CHECK;
            end
`else
            state_s = IDLE;
`endif
         end
         FINISH: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Parser state register; reset aborts any frame in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Status outputs registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_ready_r     <= 1'b1;
         cpu_hold_r     <= 1'b0;
         mem_en_write_r <= 1'b0;
         done_r         <= 1'b0;
         error_r        <= 1'b0;
      end else begin
         in_ready_r     <= (state_s != WRITE) && (state_s != FINISH);
         cpu_hold_r     <= (state_s != IDLE);
         mem_en_write_r <= (state_s == WRITE);
         done_r         <= (state_s == FINISH) && fin_ok_s;
         error_r        <= (state_s == FINISH) && !fin_ok_s;
      end
   end

   // Captured header fields and the word index within the frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         base_r <= {ADDR_SIZE{1'b0}};
         len_r  <= {ADDR_SIZE{1'b0}};
         idx_r  <= {ADDR_SIZE{1'b0}};
      end else begin
         if ((state_r == ADDR) && sh_full_s) begin
            base_r <= field_s;
         end else begin
            base_r <= base_r;
         end
         if ((state_r == LEN) && sh_full_s) begin
            len_r <= field_s;
            idx_r <= {ADDR_SIZE{1'b0}};
         end else if (state_r == WRITE) begin
            len_r <= len_r;
            idx_r <= idx_inc_s;
         end else begin
            len_r <= len_r;
            idx_r <= idx_r;
         end
      end
   end

   // Memory address/data: loaded as the last byte of a word arrives, held otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_data_r <= {WORD_SIZE{1'b0}};
         mem_addr_r <= {ADDR_SIZE{1'b0}};
      end else if ((state_r == DATA) && sh_full_s) begin
         mem_data_r <= sh_value_s[WORD_SIZE-1:0];
         mem_addr_r <= base_r + idx_r;
      end else begin
         mem_data_r <= mem_data_r;
         mem_addr_r <= mem_addr_r;
      end
   end

`ifdef LOADER_CHECKSUM_EN
   // XOR of every byte after SYNC (header and data), restarted at each SYNC.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chk_r <= 8'h00;
      end else if ((state_r == IDLE) && accept_s) begin
         chk_r <= 8'h00;
      end else if (accept_s && ((state_r == ADDR) || (state_r == LEN) || (state_r == DATA))) begin
         chk_r <= chk_update(chk_r, in_data);
      end else begin
         chk_r <= chk_r;
      end
   end
`endif

   assign in_ready     = in_ready_r;
   assign cpu_hold     = cpu_hold_r;
   assign mem_en_write = mem_en_write_r;
   assign mem_data     = mem_data_r;
   assign mem_addr     = mem_addr_r;
   assign done         = done_r;
   assign error        = error_r;

endmodule
